// File: rtl/fifo_put_ctrl.sv
// Put-side controller for the mixed-clock FIFO: rotates a one-hot put token over
// the register-cell ring and accepts a word only while the ring is not full.
module fifo_put_ctrl #(
    parameter int N_CELLS = 4,
    parameter int N_BITS  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_put,
    input  logic [N_BITS-1:0]  data_in,
    output logic               put_ack,
    input  logic [N_CELLS-1:0] cell_full,
    output logic [N_CELLS-1:0] enable_put,
    output logic [N_BITS-1:0]  data_put,
    output logic               full,
    output logic               err_ovf,
    output logic [CNT_W-1:0]   put_cnt
);

    localparam logic [N_CELLS-1:0] TOK_RST = {{(N_CELLS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Rotate left by one cell position around the ring.
    function automatic logic [N_CELLS-1:0] rotl1(input logic [N_CELLS-1:0] v);
        return {v[N_CELLS-2:0], v[N_CELLS-1]};
    endfunction

    logic [N_CELLS-1:0] tok_r;
    logic               full_r;
    logic               err_ovf_r;
    logic [CNT_W-1:0]   put_cnt_r;

    logic               accept_s;
    logic [N_CELLS-1:0] enable_s;
    logic [N_CELLS-1:0] eff_s;
    logic [N_CELLS-1:0] tok_nxt_s;
    logic               full_nxt_s;
    logic               ovf_nxt_s;
    logic [CNT_W-1:0]   cnt_nxt_s;

    // Accept decision, next token and the conservative two-cell full lookahead.
    always_comb begin
        accept_s   = 1'b0;
        enable_s   = '0;
        eff_s      = '0;
        tok_nxt_s  = tok_r;
        full_nxt_s = 1'b0;
        ovf_nxt_s  = err_ovf_r;
        cnt_nxt_s  = put_cnt_r;

        accept_s = req_put & ~full_r;
        enable_s = tok_r & {N_CELLS{accept_s}};
        // A cell being written this cycle counts as occupied next cycle.
        eff_s    = cell_full | enable_s;

        if (accept_s) begin
            tok_nxt_s = rotl1(tok_r);
            cnt_nxt_s = put_cnt_r + CNT_ONE;
        end else begin
            tok_nxt_s = tok_r;
            cnt_nxt_s = put_cnt_r;
        end

        // Full when either the next token cell or the one after it is occupied.
        full_nxt_s = |(eff_s & (tok_nxt_s | rotl1(tok_nxt_s)));

        if (req_put && full_r) begin
            ovf_nxt_s = 1'b1;
        end else begin
            ovf_nxt_s = err_ovf_r;
        end
    end

    // State registers; reset returns the token to cell 0 and clears status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_r     <= TOK_RST;
            full_r    <= 1'b0;
            err_ovf_r <= 1'b0;
            put_cnt_r <= '0;
        end else begin
            tok_r     <= tok_nxt_s;
            full_r    <= full_nxt_s;
            err_ovf_r <= ovf_nxt_s;
            put_cnt_r <= cnt_nxt_s;
        end
    end

    assign put_ack    = accept_s;
    assign enable_put = enable_s;
    assign data_put   = data_in;
    assign full       = full_r;
    assign err_ovf    = err_ovf_r;
    assign put_cnt    = put_cnt_r;

endmodule

// File: tb/tb_fifo_put_ctrl.sv
// Directed bench for fifo_put_ctrl: the bench models the cell ring (contents and
// full flags) and checks acks, strobes, full, overflow and the put counter.
module tb_fifo_put_ctrl;

    localparam int NC = 4;
    localparam int NB = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          req_put;
    logic [NB-1:0] data_in;
    logic          put_ack;
    logic [NC-1:0] cell_full;
    logic [NC-1:0] enable_put;
    logic [NB-1:0] data_put;
    logic          full;
    logic          err_ovf;
    logic [CW-1:0] put_cnt;

    logic [NB-1:0] mem [NC];
    logic [NC-1:0] last_en;
    int            n_pass  = 0;
    int            n_total = 0;

    fifo_put_ctrl #(.N_CELLS(NC), .N_BITS(NB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_put    (req_put),
        .data_in    (data_in),
        .put_ack    (put_ack),
        .cell_full  (cell_full),
        .enable_put (enable_put),
        .data_put   (data_put),
        .full       (full),
        .err_ovf    (err_ovf),
        .put_cnt    (put_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: cells strobed before the edge latch data and become full.
    task automatic tick();
        logic [NC-1:0] en;
        logic [NB-1:0] d;
        en = enable_put;
        d  = data_put;
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (en[i]) begin
                mem[i]       = d;
                cell_full[i] = 1'b1;
            end
        end
        last_en = en;
    endtask

    // Accepted put followed by draining every cell except the one just written.
    task automatic put_drain(input string tag, input logic [NB-1:0] d, input logic [NC-1:0] exp_en);
        req_put = 1'b1;
        data_in = d;
        #1;
        chk({tag, "_ack"}, 32'(put_ack), 32'd1);
        chk({tag, "_en"}, 32'(enable_put), 32'(exp_en));
        tick();
        cell_full = cell_full & last_en;
        chk({tag, "_full"}, 32'(full), 32'd0);
    endtask

    task automatic pulse_reset();
        req_put   = 1'b0;
        cell_full = '0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NC-1:0] e;
        rst_n     = 1'b0;
        req_put   = 1'b0;
        data_in   = '0;
        cell_full = '0;
        last_en   = '0;
        #2;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(err_ovf), 32'd0);
        chk("rst_cnt", 32'(put_cnt), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset check: build tok=0100, full=1, err_ovf=1, put_cnt=6, then reset.
        for (int k = 0; k < 6; k++) begin
            e = 4'b0001 << (k % 4);
            put_drain("pre", 32'h10 + k, e);
        end
        req_put   = 1'b0;
        cell_full = 4'b1000;
        tick();
        chk("pre_full", 32'(full), 32'd1);
        chk("pre_cnt", 32'(put_cnt), 32'd6);
        req_put = 1'b1;
        data_in = 32'hEE;
        #1;
        chk("pre_ovf_ack", 32'(put_ack), 32'd0);
        chk("pre_ovf_en", 32'(enable_put), 32'd0);
        tick();
        chk("pre_ovf", 32'(err_ovf), 32'd1);
        chk("pre_ovf_cnt", 32'(put_cnt), 32'd6);
        req_put = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ovf", 32'(err_ovf), 32'd0);
        chk("arst_cnt", 32'(put_cnt), 32'd0);
        cell_full = '0;
        #1;
        rst_n   = 1'b1;
        req_put = 1'b1;
        data_in = 32'h0;
        #1;
        chk("arst_tok", 32'(enable_put), 32'h1);
        chk("arst_ack", 32'(put_ack), 32'd1);

        // Fill with no reads.
        for (int k = 0; k < 3; k++) begin
            data_in = 32'hA0 + k;
            #1;
            chk("fill_ack", 32'(put_ack), 32'd1);
            chk("fill_en", 32'(enable_put), 32'(4'b0001 << k));
            chk("fill_data", data_put, 32'hA0 + k);
            tick();
            chk("fill_full", 32'(full), (k == 2) ? 32'd1 : 32'd0);
            chk("fill_cnt", 32'(put_cnt), 32'(k + 1));
        end
        data_in = 32'hA3;
        #1;
        chk("fill_a3_ack", 32'(put_ack), 32'd0);
        chk("fill_a3_en", 32'(enable_put), 32'd0);
        tick();
        chk("fill_ovf", 32'(err_ovf), 32'd1);
        chk("fill_full2", 32'(full), 32'd1);
        chk("fill_cnt3", 32'(put_cnt), 32'd3);
        chk("cell0", mem[0], 32'hA0);
        chk("cell1", mem[1], 32'hA1);
        chk("cell2", mem[2], 32'hA2);
        req_put = 1'b0;

        // Release from full: token at cell 3, window is cells 3 and 0.
        cell_full[1] = 1'b0;
        tick();
        chk("rel_one_free", 32'(full), 32'd1);
        tick();
        chk("rel_one_free2", 32'(full), 32'd1);
        cell_full[0] = 1'b0;
        #1;
        chk("rel_reg_hold", 32'(full), 32'd1);
        tick();
        chk("rel_fall", 32'(full), 32'd0);
        req_put = 1'b1;
        data_in = 32'hB3;
        #1;
        chk("rel_ack", 32'(put_ack), 32'd1);
        chk("rel_en", 32'(enable_put), 32'h8);
        tick();
        chk("rel_cell3", mem[3], 32'hB3);
        chk("rel_full", 32'(full), 32'd0);
        chk("rel_cnt", 32'(put_cnt), 32'd4);
        req_put = 1'b0;

        // Wrap-around with draining.
        pulse_reset();
        for (int k = 0; k < 9; k++) begin
            e = 4'b0001 << (k % 4);
            put_drain("wrap", 32'hC0 + k, e);
        end
        chk("wrap_cnt", 32'(put_cnt), 32'd9);
        chk("wrap_ovf", 32'(err_ovf), 32'd0);

        // Simultaneous put into cell 3 and release of cell 0.
        put_drain("sim_pre1", 32'hD1, 4'b0010);
        put_drain("sim_pre2", 32'hD2, 4'b0100);
        req_put   = 1'b0;
        cell_full = 4'b0001;
        #1;
        chk("sim_full_pre", 32'(full), 32'd0);
        req_put   = 1'b1;
        data_in   = 32'hE3;
        cell_full = 4'b0000;
        #1;
        chk("sim_ack", 32'(put_ack), 32'd1);
        chk("sim_en", 32'(enable_put), 32'h8);
        tick();
        chk("sim_full", 32'(full), 32'd0);
        chk("sim_cell3", mem[3], 32'hE3);
        chk("sim_cnt", 32'(put_cnt), 32'd12);
        req_put = 1'b0;

        // Counter wrap with a 4-bit counter.
        pulse_reset();
        for (int k = 0; k < 17; k++) begin
            e = 4'b0001 << (k % 4);
            put_drain("cw", 32'hF00 + k, e);
            if (k == 14) chk("cw_cnt15", 32'(put_cnt), 32'd15);
            if (k == 15) chk("cw_cnt0", 32'(put_cnt), 32'd0);
        end
        chk("cw_cnt1", 32'(put_cnt), 32'd1);
        req_put = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
